// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared floating-point FSM states and exponent bias helper
package fp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        NORM   = 2'd2,
        DONE   = 2'd3
    } fp_state_e;

    function automatic int fp_bias(input int exp_len);
        return (1 << (exp_len - 1)) - 1;
    endfunction

endpackage

// File: rtl/fp_mantissa_div.sv
// rtl/fp_mantissa_div.sv - iterative restoring divider of {1,mant_a} by {1,mant_b}
// Produces one quotient bit per cycle; quotient MSB is the integer bit.
module fp_mantissa_div #(
    parameter int MANTISSA_LEN = 23
) (
    input  logic                    clk,
    input  logic                    reset_neg,
    input  logic                    i_start,
    input  logic [MANTISSA_LEN-1:0] i_mant_a,
    input  logic [MANTISSA_LEN-1:0] i_mant_b,
    output logic                    o_done,
    output logic [MANTISSA_LEN+1:0] o_quotient
);

    localparam int QW = MANTISSA_LEN + 2;
    localparam int CW = $clog2(QW + 1);

    logic [QW-1:0]         r_rem;
    logic [QW-1:0]         r_quot;
    logic [MANTISSA_LEN:0] r_div;
    logic [CW-1:0]         r_count;
    logic                  r_busy;

    logic [QW-1:0] w_div_ext;
    logic [QW-1:0] w_diff;
    logic          w_ge;

    assign w_div_ext  = {1'b0, r_div};
    assign w_ge       = (r_rem >= w_div_ext);
    assign w_diff     = w_ge ? (r_rem - w_div_ext) : r_rem;
    // Asserted during the cycle that computes the final quotient bit
    assign o_done     = r_busy && (r_count == CW'(QW - 1));
    assign o_quotient = r_quot;

    always_ff @(posedge clk or negedge reset_neg) begin
        if (!reset_neg) begin
            r_rem   <= '0;
            r_quot  <= '0;
            r_div   <= '0;
            r_count <= '0;
            r_busy  <= 1'b0;
        end else if (i_start) begin
            r_rem   <= {2'b01, i_mant_a};
            r_div   <= {1'b1, i_mant_b};
            r_quot  <= '0;
            r_count <= '0;
            r_busy  <= 1'b1;
        end else if (r_busy) begin
            r_rem   <= w_diff << 1;
            r_quot  <= {r_quot[QW-2:0], w_ge};
            r_count <= r_count + CW'(1);
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/float_point_divider.sv
// rtl/float_point_divider.sv - multi-cycle floating-point divider with valid/ready handshake
// Special cases share the normal latency: the mantissa divider always runs.
module float_point_divider
    import fp_pkg::*;
#(
    parameter int EXP_LEN      = 8,
    parameter int MANTISSA_LEN = 23
) (
    input  logic                            clk,
    input  logic                            reset_neg,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [EXP_LEN+MANTISSA_LEN:0]   input_a,
    input  logic [EXP_LEN+MANTISSA_LEN:0]   input_b,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [EXP_LEN+MANTISSA_LEN:0]   output_quotient,
    output logic                            div_by_zero
);

    localparam int W = EXP_LEN + MANTISSA_LEN + 1;
    localparam logic signed [EXP_LEN+1:0] BIAS    = (EXP_LEN+2)'(fp_bias(EXP_LEN));
    localparam logic signed [EXP_LEN+1:0] EXP_MAX = {2'b00, {EXP_LEN{1'b1}}};
    localparam logic signed [EXP_LEN+1:0] EXP_ONE = (EXP_LEN+2)'(1);

    fp_state_e r_state;
    fp_state_e w_next;

    logic                      w_accept;
    logic                      w_div_done;
    logic [MANTISSA_LEN+1:0]   w_div_q;

    logic                      w_a_sign;
    logic                      w_b_sign;
    logic [EXP_LEN-1:0]        w_a_exp;
    logic [EXP_LEN-1:0]        w_b_exp;
    logic signed [EXP_LEN+1:0] w_exp_pre;

    logic                      r_sign;
    logic                      r_a_zero;
    logic                      r_b_zero;
    logic signed [EXP_LEN+1:0] r_exp;
    logic [W-1:0]              r_quotient;
    logic                      r_dbz;

    logic signed [EXP_LEN+1:0] w_norm_exp;
    logic [MANTISSA_LEN-1:0]   w_norm_mant;
    logic [W-1:0]              w_res;
    logic                      w_res_dbz;

    assign w_a_sign  = input_a[W-1];
    assign w_b_sign  = input_b[W-1];
    assign w_a_exp   = input_a[W-2 -: EXP_LEN];
    assign w_b_exp   = input_b[W-2 -: EXP_LEN];
    assign w_exp_pre = $signed({2'b00, w_a_exp}) - $signed({2'b00, w_b_exp}) + BIAS;

    fp_mantissa_div #(
        .MANTISSA_LEN(MANTISSA_LEN)
    ) u_mant_div (
        .clk        (clk),
        .reset_neg  (reset_neg),
        .i_start    (w_accept),
        .i_mant_a   (input_a[MANTISSA_LEN-1:0]),
        .i_mant_b   (input_b[MANTISSA_LEN-1:0]),
        .o_done     (w_div_done),
        .o_quotient (w_div_q)
    );

    always_ff @(posedge clk or negedge reset_neg) begin
        if (!reset_neg) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_accept = 1'b1;
                    w_next   = DIVIDE;
                end
            end
            DIVIDE: begin
                if (w_div_done) begin
                    w_next = NORM;
                end
            end
            NORM: begin
                w_next = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign in_ready        = (r_state == IDLE);
    assign out_valid       = (r_state == DONE);
    assign output_quotient = r_quotient;
    assign div_by_zero     = r_dbz;

    // A quotient below 1.0 has its leading one in the first fractional bit
    assign w_norm_exp  = w_div_q[MANTISSA_LEN+1] ? r_exp : (r_exp - EXP_ONE);
    assign w_norm_mant = w_div_q[MANTISSA_LEN+1] ? w_div_q[MANTISSA_LEN:1]
                                                 : w_div_q[MANTISSA_LEN-1:0];

    always_comb begin
        w_res     = '0;
        w_res_dbz = 1'b0;
        if (r_b_zero) begin
            w_res     = {r_sign, {EXP_LEN{1'b1}}, {MANTISSA_LEN{1'b0}}};
            w_res_dbz = 1'b1;
        end else if (r_a_zero) begin
            w_res = '0;
        end else if (w_norm_exp >= EXP_MAX) begin
            w_res = {r_sign, {EXP_LEN{1'b1}}, {MANTISSA_LEN{1'b0}}};
        end else if (w_norm_exp[EXP_LEN+1] || (w_norm_exp == '0)) begin
            w_res = '0;
        end else begin
            w_res = {r_sign, w_norm_exp[EXP_LEN-1:0], w_norm_mant};
        end
    end

    always_ff @(posedge clk or negedge reset_neg) begin
        if (!reset_neg) begin
            r_sign     <= 1'b0;
            r_a_zero   <= 1'b0;
            r_b_zero   <= 1'b0;
            r_exp      <= '0;
            r_quotient <= '0;
            r_dbz      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sign   <= w_a_sign ^ w_b_sign;
                r_a_zero <= (w_a_exp == '0);
                r_b_zero <= (w_b_exp == '0);
                r_exp    <= w_exp_pre;
            end
            if (r_state == NORM) begin
                r_quotient <= w_res;
                r_dbz      <= w_res_dbz;
            end
        end
    end

endmodule

// File: doc/float_point_divider.md
FLOAT_POINT_DIVIDER -- requirements
Module: float_point_divider

Interface
REQ-001 The block SHALL have parameter EXP_LEN, default 8, giving the number of exponent bits.
REQ-002 The block SHALL have parameter MANTISSA_LEN, default 23, giving the number of stored mantissa bits, excluding the hidden bit.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_neg, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: dividend and divisor are valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept an operation.
REQ-007 The block SHALL have port input_a, input, EXP_LEN+MANTISSA_LEN+1 bits: the dividend as {sign, exp, mantissa}.
REQ-008 The block SHALL have port input_b, input, EXP_LEN+MANTISSA_LEN+1 bits: the divisor, in the same format.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the quotient is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the quotient.
REQ-011 The block SHALL have port output_quotient, output, EXP_LEN+MANTISSA_LEN+1 bits: the quotient.
REQ-012 The block SHALL have port div_by_zero, output, 1 bit: set when the divisor was zero, valid with out_valid.

Function
REQ-013 The FSM SHALL have states IDLE, DIVIDE, NORM and DONE; in_ready SHALL be 1 only in IDLE.
REQ-014 In IDLE, in_valid=1 SHALL capture both operands and go to DIVIDE; in_valid=0 SHALL keep the FSM in IDLE.
REQ-015 DIVIDE SHALL run a restoring division of {1,mant_a} by {1,mant_b}, producing one quotient bit per cycle for exactly MANTISSA_LEN+2 cycles, then go to NORM.
REQ-016 NORM SHALL last one cycle and then go to DONE with out_valid=1, so out_valid rises exactly MANTISSA_LEN+3 edges after the accepting edge (26 with the default parameters).
REQ-017 In DONE, output_quotient, div_by_zero and out_valid SHALL hold stable until out_ready=1, then the FSM SHALL return to IDLE on that edge.
REQ-018 The result sign SHALL be sign_a XOR sign_b, except that a zero result SHALL have sign 0.
REQ-019 The pre-normalised exponent SHALL be computed as exp_a - exp_b + BIAS in a signed EXP_LEN+2-bit width, where BIAS = 2^(EXP_LEN-1)-1.
REQ-020 Normalisation: if the quotient MSB is 0 (quotient <1), NORM SHALL shift the quotient left by 1 and decrement the exponent; the mantissa is truncated with no rounding.
REQ-021 An operand with an exponent field of 0 SHALL be treated as zero (denormals flushed).
REQ-022 A zero dividend with a nonzero divisor SHALL give an all-zero output.
REQ-023 A zero divisor SHALL give {sign, all-ones exp, zero mantissa} with div_by_zero=1; a 0/0 divide SHALL give the same result.
REQ-024 A final exponent >= 2^EXP_LEN-1 SHALL saturate to infinity; a final exponent <= 0 SHALL flush the result to zero.
REQ-025 Latency SHALL be identical for special-case and normal operands.

Reset
REQ-026 While reset_neg=0, the FSM SHALL be in IDLE with in_ready=1, out_valid=0, output_quotient=0, div_by_zero=0, and all datapath registers cleared.
REQ-027 Reset asserted mid-operation SHALL abort the operation with no output; the first operation accepted after release SHALL complete normally.

Structure
REQ-028 Shared package fp_pkg SHALL hold the FSM state enum and a BIAS function of EXP_LEN, reused by the multiplier.
REQ-029 The iterative restoring mantissa divider SHALL be one sub-module, fp_mantissa_div, with start/done signals; unpacking, exponent logic and the FSM SHALL stay in the top level.

Verification (defaults: EXP_LEN=8, MANTISSA_LEN=23)
REQ-030 0x40C00000 / 0x40000000 (6.0/2.0) -> 0x40400000, div_by_zero=0, out_valid 26 edges after accept.
REQ-031 0x3F800000 / 0x40400000 (1.0/3.0) -> 0x3EAAAAAA (NORM shift taken, truncated); 0xC0F00000 / 0x40200000 (-7.5/2.5) -> 0xC0400000.
REQ-032 0x00000000 / 0x40A00000 -> 0x00000000; 0x3F800000 / 0x00000000 -> 0x7F800000 with div_by_zero=1; both after 26 edges.
REQ-033 0x7F000000 / 0x00800000 -> 0x7F800000 (overflow saturates); 0x00800000 / 0x7F000000 -> 0x00000000 (underflow flush).
REQ-034 out_ready=0 for 10 cycles in DONE -> output held stable, in_ready=0 and new in_valid ignored; out_ready=1 -> IDLE on the next edge.
REQ-035 reset_neg pulsed low at DIVIDE cycle 10 -> out_valid=0 and in_ready=1 immediately; the next operation, 6.0/2.0, returns 0x40400000.
